// File: rtl/m_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Sizing defaults, PC step and the entry layout stored in the FIFO.
package m_fetch_queue_pkg;

   localparam int unsigned DEPTH_DEF    = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INC       = 32'd4;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Circular buffer of 64-bit fetch entries with synchronous flush.
// The array is not reset; the consumer masks the head using count.
module m_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic          w_clk,
   input  logic          w_rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [63:0]   wr_data,
   output logic [63:0]   rd_data,
   output logic [CW-1:0] count
);

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge w_clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/m_fetch_queue.sv
// Fetch PC generation plus a registered queue feeding decode.
// Redirect flushes the queue and restarts fetch from the aligned target.
module m_fetch_queue
   import m_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   output logic [31:0] w_imem_adr,
   input  logic [31:0] w_imem_data,
   input  logic        w_redirect,
   input  logic [31:0] w_redirect_pc,
   output logic        w_valid,
   input  logic        w_ready,
   output logic [31:0] w_inst,
   output logic [31:0] w_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [31:0]   r_pc;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   fetch_entry_t  tail;
   fetch_entry_t  head;

   assign w_imem_adr = r_pc;
   assign w_valid    = (count != '0);
   assign pop        = w_valid & w_ready & ~w_redirect;
   // A pop in the same cycle frees a slot, so a full queue still accepts a fetch.
   assign push       = ~w_redirect & ((count < CW'(DEPTH)) | pop);

   assign tail.pc    = r_pc;
   assign tail.inst  = w_imem_data;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pc <= RESET_PC;
      end else if (w_redirect) begin
         r_pc <= align_pc(w_redirect_pc);
      end else if (push) begin
         r_pc <= r_pc + PC_INC;
      end
   end

   m_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .w_clk   (w_clk),
      .w_rst_n (w_rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (w_redirect),
      .wr_data (tail),
      .rd_data (head),
      .count   (count)
   );

   assign w_inst = w_valid ? head.inst : '0;
   assign w_pc   = w_valid ? head.pc   : '0;

endmodule

// File: tb/tb_m_fetch_queue.sv
// Self-checking bench for m_fetch_queue: expected PC stream held in a scoreboard queue.
// Instruction memory model returns (pc>>2)+1, so imem[i] = i+1.
module tb_m_fetch_queue;

   logic        w_clk = 1'b0;
   logic        w_rst_n = 1'b0;
   logic [31:0] w_imem_adr;
   logic [31:0] w_imem_data;
   logic        w_redirect = 1'b0;
   logic [31:0] w_redirect_pc = 32'h0;
   logic        w_valid;
   logic        w_ready = 1'b0;
   logic [31:0] w_inst;
   logic [31:0] w_pc;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc [$];
   logic [31:0] e;

   m_fetch_queue dut (
      .w_clk         (w_clk),
      .w_rst_n       (w_rst_n),
      .w_imem_adr    (w_imem_adr),
      .w_imem_data   (w_imem_data),
      .w_redirect    (w_redirect),
      .w_redirect_pc (w_redirect_pc),
      .w_valid       (w_valid),
      .w_ready       (w_ready),
      .w_inst        (w_inst),
      .w_pc          (w_pc)
   );

   always #5 w_clk = ~w_clk;

   assign w_imem_data = (w_imem_adr >> 2) + 32'd1;

   task automatic tick;
      @(posedge w_clk);
      #1;
   endtask

   task automatic sb_load(input logic [31:0] start, input int n);
      exp_pc.delete();
      for (int i = 0; i < n; i++) exp_pc.push_back(start + 32'(4 * i));
   endtask

   task automatic test_reset;
      w_rst_n = 1'b0;
      w_ready = 1'b0;
      #3;
      checks++;
      if (w_valid !== 1'b0 || w_pc !== 32'h0 || w_inst !== 32'h0) begin
         errors++;
         $display("FAIL reset_out: valid=%b pc=%h inst=%h, want 0/0/0", w_valid, w_pc, w_inst);
      end
      checks++;
      if (w_imem_adr !== 32'h0) begin
         errors++;
         $display("FAIL reset_pc: adr=%h want 00000000", w_imem_adr);
      end
      repeat (2) tick();
      checks++;
      if (w_valid !== 1'b0 || w_imem_adr !== 32'h0) begin
         errors++;
         $display("FAIL reset_held: valid=%b adr=%h want 0/00000000", w_valid, w_imem_adr);
      end
   endtask

   task automatic test_stream;
      w_ready = 1'b1;
      sb_load(32'h0, 20);
      w_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (w_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_valid: cycle %0d valid=%b want 1", i, w_valid);
         end
         if (w_valid && w_ready) begin
            e = exp_pc.pop_front();
            checks++;
            if (w_pc !== e || w_inst !== (e >> 2) + 32'd1) begin
               errors++;
               $display("FAIL stream_data: pc=%h inst=%h want %h/%h", w_pc, w_inst, e, (e >> 2) + 32'd1);
            end
         end
      end
   endtask

   task automatic test_async_reset;
      #2;
      w_rst_n = 1'b0;
      #1;
      checks++;
      if (w_valid !== 1'b0 || w_pc !== 32'h0 || w_inst !== 32'h0 || w_imem_adr !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: valid=%b pc=%h inst=%h adr=%h want 0/0/0/0",
                  w_valid, w_pc, w_inst, w_imem_adr);
      end
      w_ready = 1'b0;
      tick();
   endtask

   task automatic test_backpressure;
      sb_load(32'h0, 20);
      w_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_inst !== 32'h1) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d valid=%b pc=%h inst=%h want 1/0/1", i, w_valid, w_pc, w_inst);
         end
      end
      checks++;
      if (w_imem_adr !== 32'd16) begin
         errors++;
         $display("FAIL stall_sat: adr=%h want 00000010", w_imem_adr);
      end
      // single accept while full: push and pop together
      w_ready = 1'b1;
      e = exp_pc.pop_front();
      checks++;
      if (w_pc !== e || w_inst !== (e >> 2) + 32'd1) begin
         errors++;
         $display("FAIL full_pop: pc=%h inst=%h want %h/%h", w_pc, w_inst, e, (e >> 2) + 32'd1);
      end
      tick();
      w_ready = 1'b0;
      checks++;
      if (w_imem_adr !== 32'd20) begin
         errors++;
         $display("FAIL full_push: adr=%h want 00000014", w_imem_adr);
      end
      tick();
      checks++;
      if (w_imem_adr !== 32'd20 || w_pc !== 32'd4) begin
         errors++;
         $display("FAIL full_count: adr=%h pc=%h want 00000014/00000004", w_imem_adr, w_pc);
      end
      w_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (w_valid && w_ready) begin
            e = exp_pc.pop_front();
            checks++;
            if (w_pc !== e || w_inst !== (e >> 2) + 32'd1) begin
               errors++;
               $display("FAIL drain_data: pc=%h inst=%h want %h/%h", w_pc, w_inst, e, (e >> 2) + 32'd1);
            end
         end else begin
            checks++;
            errors++;
            $display("FAIL drain_valid: valid=%b want 1", w_valid);
         end
         tick();
      end
   endtask

   task automatic test_redirect;
      w_rst_n = 1'b0;
      #1;
      w_ready = 1'b0;
      tick();
      w_rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (w_imem_adr !== 32'd12 || w_pc !== 32'h0) begin
         errors++;
         $display("FAIL redir_setup: adr=%h pc=%h want 0000000c/00000000", w_imem_adr, w_pc);
      end
      w_redirect    = 1'b1;
      w_redirect_pc = 32'h0000_0103;
      tick();
      w_redirect = 1'b0;
      checks++;
      if (w_valid !== 1'b0 || w_pc !== 32'h0 || w_inst !== 32'h0) begin
         errors++;
         $display("FAIL redir_flush: valid=%b pc=%h inst=%h want 0/0/0", w_valid, w_pc, w_inst);
      end
      checks++;
      if (w_imem_adr !== 32'h0000_0100) begin
         errors++;
         $display("FAIL redir_pc: adr=%h want 00000100", w_imem_adr);
      end
      sb_load(32'h0000_0100, 10);
      w_ready = 1'b1;
      tick();
      checks++;
      if (w_valid !== 1'b1 || w_pc !== 32'h0000_0100) begin
         errors++;
         $display("FAIL redir_first: valid=%b pc=%h want 1/00000100", w_valid, w_pc);
      end
      for (int i = 0; i < 4; i++) begin
         if (w_valid && w_ready) begin
            e = exp_pc.pop_front();
            checks++;
            if (w_pc !== e || w_inst !== (e >> 2) + 32'd1) begin
               errors++;
               $display("FAIL redir_data: pc=%h inst=%h want %h/%h", w_pc, w_inst, e, (e >> 2) + 32'd1);
            end
         end
         tick();
      end
   endtask

   task automatic test_wrap;
      w_redirect    = 1'b1;
      w_redirect_pc = 32'hFFFF_FFF8;
      tick();
      w_redirect = 1'b0;
      checks++;
      if (w_imem_adr !== 32'hFFFF_FFF8 || w_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap_redir: adr=%h valid=%b want fffffff8/0", w_imem_adr, w_valid);
      end
      sb_load(32'hFFFF_FFF8, 8);
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (w_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_valid: cycle %0d valid=%b want 1", i, w_valid);
         end else begin
            e = exp_pc.pop_front();
            checks++;
            if (w_pc !== e || w_inst !== (e >> 2) + 32'd1) begin
               errors++;
               $display("FAIL wrap_data: pc=%h inst=%h want %h/%h", w_pc, w_inst, e, (e >> 2) + 32'd1);
            end
         end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_async_reset();
      test_backpressure();
      test_redirect();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/m_fetch_queue.md
M_FETCH_QUEUE -- requirements
Module: m_fetch_queue

Interface
REQ-001: Parameter DEPTH, default 4, SHALL set the number of queue entries (power of two, 2..16).
REQ-002: Parameter RESET_PC, default 32'h00000000, SHALL set the fetch PC loaded at reset.
REQ-003: w_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: w_rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005: w_imem_adr  output  32  SHALL carry the current fetch PC to the instruction memory.
REQ-006: w_imem_data  input  32  SHALL be the instruction word, combinationally valid in the same cycle as w_imem_adr.
REQ-007: w_redirect  input  1  SHALL request a flush and PC change (branch/jump taken).
REQ-008: w_redirect_pc  input  32  SHALL be the new fetch PC when w_redirect=1.
REQ-009: w_valid  output  1  SHALL indicate that a fetched instruction is presented to decode.
REQ-010: w_ready  input  1  SHALL indicate that decode accepts the presented instruction this cycle.
REQ-011: w_inst  output  32  SHALL be the instruction at the queue head.
REQ-012: w_pc  output  32  SHALL be the PC of the instruction at the queue head.

Function
REQ-013: w_imem_adr SHALL equal r_pc, the internal 32-bit fetch PC register.
REQ-014: push = ~w_redirect & (count<DEPTH | pop); on push, {r_pc, w_imem_data} SHALL enter the tail and r_pc SHALL advance by 4.
REQ-015: PC arithmetic SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 32'h00000000).
REQ-016: pop = w_valid & w_ready & ~w_redirect; on pop, the head entry SHALL be removed.
REQ-017: w_valid SHALL be 1 exactly when count != 0; w_inst and w_pc SHALL be 0 when count = 0.
REQ-018: Latency: an instruction fetched in cycle N SHALL appear at w_valid no earlier than cycle N+1 (registered queue, no bypass).
REQ-019: Full with pop in the same cycle SHALL permit a push; count stays DEPTH.
REQ-020: Empty: no pop; push alone SHALL raise count to 1.
REQ-021: w_redirect=1 SHALL, at that edge, set count to 0, reset both pointers, load r_pc with {w_redirect_pc[31:2], 2'b00}, and discard the current w_imem_data; redirect wins over simultaneous push/pop.
REQ-022: Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-023: While w_valid=1 and w_ready=0, w_inst and w_pc SHALL remain stable until pop or redirect.

Reset
REQ-024: w_rst_n=0 SHALL immediately (no clock needed) set r_pc=RESET_PC, count=0, pointers=0, hence w_valid=0, w_inst=0, w_pc=0.
REQ-025: Reset asserted mid-operation SHALL discard all queued entries; the first fetch after release SHALL use RESET_PC.
REQ-026: Storage array contents need not be reset; outputs SHALL be masked by count.

Structure
REQ-027: A shared package SHALL hold DEPTH default, RESET_PC default, PC increment (4) and NOP encoding 32'h00000013.
REQ-028: The storage SHALL be one sub-module, m_fetch_fifo (64-bit entries, push/pop/flush, count output); PC logic and handshake remain in m_fetch_queue.

Verification
REQ-029: Reset release, w_ready=1, imem[i]=i+1 -> from cycle 2 on, one instruction per cycle: w_pc=0,4,8..., w_inst=1,2,3...
REQ-030: w_ready=0 for 6 cycles from reset -> count saturates at 4, r_pc=16, w_pc=0 held stable; w_ready=1 -> pc 0,4,8,12,16 delivered in order, none lost or duplicated.
REQ-031: Full queue, w_ready=1 for one cycle -> simultaneous push/pop, count stays 4, r_pc advances by 4.
REQ-032: w_redirect=1, w_redirect_pc=32'h0000_0103 with 3 entries queued -> next cycle w_valid=0, r_pc=32'h0000_0100; following cycle w_pc=32'h100.
REQ-033: Redirect to 32'hFFFFFFF8 -> fetched PCs FFFFFFF8, FFFFFFFC, 00000000.
REQ-034: w_rst_n pulsed low mid-stream (between clock edges) -> w_valid=0 immediately; after release first w_pc=RESET_PC.
